// File: rtl/pad_pkg.sv
// Shared SHAKE256 constants for the absorb-path padder.
//   RATE         : rate block width in bits (SHAKE256)
//   LEN_W        : width of the message-length field
//   SHAKE_SUFFIX : domain suffix 1111 followed by the leading pad 1
//   clamp_len    : saturates a length to RATE
package pad_pkg;

  localparam int unsigned RATE  = 1088;
  localparam int unsigned LEN_W = 11;

  localparam logic [4:0] SHAKE_SUFFIX = 5'b11111;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(RATE)) ? LEN_W'(RATE) : len;
  endfunction

endpackage

// File: rtl/pad_mask_gen.sv
// Thermometer decode of a (clamped) message length.
//   len           in   LEN_W  message length L, already clamped to 0..RATE
//   keep_mask     out  RATE   bit i set when i >= RATE-L (message bits, MSB-first)
//   suffix_onehot out  RATE   single bit at RATE-1-L; all-zero when L = RATE
module pad_mask_gen
  import pad_pkg::*;
(
  input  logic [LEN_W-1:0] len,
  output logic [RATE-1:0]  keep_mask,
  output logic [RATE-1:0]  suffix_onehot
);

  always_comb begin
    keep_mask     = '0;
    suffix_onehot = '0;
    for (int unsigned i = 0; i < RATE; i++) begin
      keep_mask[i]     = (i + 32'(len) >= RATE);
      suffix_onehot[i] = (i + 32'(len) + 1 == RATE);
    end
  end

endmodule

// File: rtl/pad.sv
// SHAKE256 message padder: appends suffix 1111 and pad10*1 to the final
// partial block, spilling into a second block when fewer than 6 bits are free.
// Outputs are registered (1-cycle latency).
//   clk, rst     clock, synchronous active-high reset
//   in_valid     data_in/data_length sampled this cycle
//   data_in      message bits, bit RATE-1 is the first bit
//   data_length  valid message bits (values above RATE are clamped)
//   out_valid    registered outputs are valid
//   data_out     padded block
//   data_next    overflow padding block (zero unless next_valid)
//   next_valid   data_next must also be absorbed
module pad
  import pad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RATE-1:0]   data_in,
  input  logic [LEN_W-1:0]  data_length,
  output logic              out_valid,
  output logic [RATE-1:0]   data_out,
  output logic [RATE-1:0]   data_next,
  output logic              next_valid
);

  logic [LEN_W-1:0] len_c;
  logic [RATE-1:0]  keep_mask;
  logic [RATE-1:0]  suffix_onehot;

  // Extended view: bits [RATE+4:5] map onto data_out, bits [4:0] onto
  // data_next[RATE-1:RATE-5], so the suffix can run off the bottom of the
  // first block with a plain shift.
  logic [RATE+4:0]  suffix_start;
  logic [RATE+4:0]  suffix_ext;
  logic             spill;
  logic [RATE-1:0]  block_c;
  logic [RATE-1:0]  next_c;

  logic             out_valid_d,  out_valid_q;
  logic             next_valid_d, next_valid_q;
  logic [RATE-1:0]  data_out_d,   data_out_q;
  logic [RATE-1:0]  data_next_d,  data_next_q;

  assign len_c = clamp_len(data_length);

  pad_mask_gen u_mask_gen (
    .len           (len_c),
    .keep_mask     (keep_mask),
    .suffix_onehot (suffix_onehot)
  );

  always_comb begin
    spill = (len_c > LEN_W'(RATE - 6));

    // A full block has no start bit inside data_out; it begins at ext bit 4.
    suffix_start = {suffix_onehot, (len_c == LEN_W'(RATE)), 4'b0000};
    suffix_ext   = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      if (SHAKE_SUFFIX[4-k]) begin
        suffix_ext = suffix_ext | (suffix_start >> k);
      end
    end

    block_c    = (data_in & keep_mask) | suffix_ext[RATE+4:5];
    block_c[0] = block_c[0] | ~spill;

    next_c = '0;
    if (spill) begin
      next_c[RATE-1 -: 5] = suffix_ext[4:0];
      next_c[0]           = 1'b1;
    end
  end

  always_comb begin
    out_valid_d  = in_valid;
    next_valid_d = next_valid_q;
    data_out_d   = data_out_q;
    data_next_d  = data_next_q;
    if (in_valid) begin
      next_valid_d = spill;
      data_out_d   = block_c;
      data_next_d  = next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      next_valid_q <= 1'b0;
      data_out_q   <= '0;
      data_next_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      next_valid_q <= next_valid_d;
      data_out_q   <= data_out_d;
      data_next_q  <= data_next_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign next_valid = next_valid_q;
  assign data_out   = data_out_q;
  assign data_next  = data_next_q;

endmodule

// File: tb/tb_pad.sv
module tb_pad;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [1087:0] data_in;
  logic [10:0]   data_length;
  logic          out_valid;
  logic [1087:0] data_out;
  logic [1087:0] data_next;
  logic          next_valid;

  int checks = 0;
  int errors = 0;

  logic [1087:0] last_out;
  logic [1087:0] last_next;
  logic          last_nv;

  always #5 clk = ~clk;

  pad dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .data_length (data_length),
    .out_valid   (out_valid),
    .data_out    (data_out),
    .data_next   (data_next),
    .next_valid  (next_valid)
  );

  // Reference: lay the two blocks out as one 2176-bit string, copy the
  // message, write the 5 suffix bits sequentially, then the closing 1.
  task automatic model(input logic [1087:0] din, input int unsigned len,
                       output logic [1087:0] o, output logic [1087:0] n,
                       output logic nv);
    logic [2175:0] s;
    int unsigned l;
    l = (len > 1088) ? 1088 : len;
    s = '0;
    for (int unsigned i = 0; i < l; i++) s[2175-i] = din[1087-i];
    for (int unsigned k = 0; k < 5; k++) s[2175-l-k] = 1'b1;
    if (1088 - l >= 6) s[1088] = 1'b1;
    else               s[0]    = 1'b1;
    o  = s[2175:1088];
    n  = s[1087:0];
    nv = (1088 - l < 6);
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [1087:0] got,
                           input logic [1087:0] exp);
    logic [1087:0] diff;
    logic [1087:0] gs;
    logic [1087:0] es;
    int idx;
    checks++;
    assert (got === exp) else begin
      errors++;
      diff = got ^ exp;
      idx  = -1;
      for (int i = 1087; i >= 0; i--) if (diff[i] !== 1'b0 && idx < 0) idx = i;
      if (idx < 0) idx = 0;
      gs = got >> ((idx / 64) * 64);
      es = exp >> ((idx / 64) * 64);
      $error("FAIL %s first bad bit %0d got chunk %h exp chunk %h",
             tag, idx, gs[63:0], es[63:0]);
    end
  endtask

  task automatic apply(input string tag, input logic [1087:0] din,
                       input logic [10:0] len);
    logic [1087:0] eo, en;
    logic env;
    model(din, int'(len), eo, en, env);
    in_valid    = 1'b1;
    data_in     = din;
    data_length = len;
    @(posedge clk); #1;
    check_bit({tag, ".out_valid"}, out_valid, 1'b1);
    check_vec({tag, ".data_out"}, data_out, eo);
    check_vec({tag, ".data_next"}, data_next, en);
    check_bit({tag, ".next_valid"}, next_valid, env);
    last_out  = eo;
    last_next = en;
    last_nv   = env;
  endtask

  task automatic idle(input string tag);
    in_valid    = 1'b0;
    data_in     = '1;
    data_length = 11'd3;
    @(posedge clk); #1;
    check_bit({tag, ".out_valid"}, out_valid, 1'b0);
    check_vec({tag, ".data_out_hold"}, data_out, last_out);
    check_vec({tag, ".data_next_hold"}, data_next, last_next);
    check_bit({tag, ".next_valid_hold"}, next_valid, last_nv);
  endtask

  function automatic logic [1087:0] rand_vec();
    logic [1087:0] v;
    for (int w = 0; w < 34; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [1087:0] v;
    logic [1087:0] ones;
    logic [1087:0] lit;
    logic [10:0]   len;

    ones        = '1;
    rst         = 1'b1;
    in_valid    = 1'b0;
    data_in     = '0;
    data_length = '0;
    @(posedge clk); @(posedge clk); #1;
    check_bit("reset.out_valid", out_valid, 1'b0);
    check_vec("reset.data_out", data_out, '0);
    check_vec("reset.data_next", data_next, '0);
    check_bit("reset.next_valid", next_valid, 1'b0);
    rst = 1'b0;

    // Directed cases, back-to-back.
    v = '0;
    v[1087:1083] = 5'b10011;
    apply("L5", v, 11'd5);
    lit = '0;
    lit[1087:1078] = 10'b1001111111;
    lit[0] = 1'b1;
    check_vec("L5.literal", data_out, lit);
    apply("L0", ones, 11'd0);
    lit = '0;
    lit[1087:1083] = 5'b11111;
    lit[0] = 1'b1;
    check_vec("L0.literal", data_out, lit);
    apply("L1082", '0, 11'd1082);
    check_vec("L1082.literal", data_out, 1088'h3F);
    apply("L1083", '0, 11'd1083);
    apply("L1087", '0, 11'd1087);
    lit = '0;
    lit[1087:1084] = 4'hF;
    lit[0] = 1'b1;
    check_vec("L1087.literal_next", data_next, lit);
    apply("L1088", ones, 11'd1088);
    apply("L2047", ones, 11'd2047);
    lit = '0;
    lit[1087:1083] = 5'b11111;
    lit[0] = 1'b1;
    check_vec("L2047.literal_next", data_next, lit);
    check_vec("L2047.literal_out", data_out, ones);
    idle("idle_after_spill");
    apply("L1077", rand_vec(), 11'd1077);
    idle("idle_after_nospill");

    // Randomized lengths, weighted toward the spill boundary.
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0: len = 11'($urandom_range(1076, 1088));
        1: len = 11'($urandom_range(0, 1088));
        2: len = 11'($urandom_range(1089, 2047));
        default: len = 11'($urandom_range(0, 10));
      endcase
      apply("rand", rand_vec(), len);
      if ($urandom_range(0, 7) == 0) idle("rand_idle");
    end

    // Reset mid-stream discards the in-flight result.
    apply("pre_rst", '0, 11'd1087);
    in_valid    = 1'b1;
    data_in     = rand_vec();
    data_length = 11'd30;
    rst         = 1'b1;
    @(posedge clk); #1;
    check_bit("midrst.out_valid", out_valid, 1'b0);
    check_vec("midrst.data_out", data_out, '0);
    check_vec("midrst.data_next", data_next, '0);
    check_bit("midrst.next_valid", next_valid, 1'b0);
    rst = 1'b0;
    apply("post_rst", rand_vec(), 11'd30);
    idle("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
